// File: rtl/compressor_pkg.sv
// Shared types, widths and helpers for the compressor datapath.
package compressor_pkg;

  localparam int unsigned DWIDTH   = 16;
  localparam int unsigned MAG_W    = DWIDTH - 1;
  localparam int unsigned ENV_FRAC = 12;
  localparam int unsigned ENV_W    = MAG_W + ENV_FRAC;
  localparam int unsigned GAIN_W   = 16;

  typedef logic [GAIN_W-1:0] gain_t;

  localparam gain_t GAIN_UNITY = 16'h8000;

  // One's-complement magnitude: never overflows, so -2^(N-1) maps to 2^(N-1)-1.
  function automatic logic [MAG_W-1:0] mag_f(input logic [DWIDTH-1:0] x);
    return x[DWIDTH-1] ? ~x[DWIDTH-2:0] : x[DWIDTH-2:0];
  endfunction

endpackage

// File: rtl/envelope_follower.sv
// Peak envelope tracker: stage A captures the magnitude, stage B applies the
// attack/release update. env_o carries ENV_FRAC fractional bits.
module envelope_follower
  import compressor_pkg::*;
#(
  parameter int unsigned ATTACK_SHIFT  = 3,
  parameter int unsigned RELEASE_SHIFT = 12
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              valid_i,
  input  logic [DWIDTH-1:0] data_i,
  output logic              valid_o,
  output logic [ENV_W-1:0]  env_o
);

  logic             va_q, va_d;
  logic             vb_q, vb_d;
  logic [MAG_W-1:0] mag_q, mag_d;
  logic [ENV_W-1:0] env_q, env_d;
  logic [ENV_W-1:0] m_c;
  logic [ENV_W-1:0] delta_c;

  always_comb begin
    va_d    = valid_i;
    mag_d   = mag_q;
    vb_d    = va_q;
    env_d   = env_q;
    m_c     = {mag_q, {ENV_FRAC{1'b0}}};
    delta_c = '0;
    if (valid_i) begin
      mag_d = mag_f(data_i);
    end
    // Fast rise toward peaks, slow decay; truncated deltas may be zero.
    if (va_q) begin
      if (m_c > env_q) begin
        delta_c = (m_c - env_q) >> ATTACK_SHIFT;
        env_d   = env_q + delta_c;
      end else begin
        delta_c = (env_q - m_c) >> RELEASE_SHIFT;
        env_d   = env_q - delta_c;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      va_q  <= 1'b0;
      vb_q  <= 1'b0;
      mag_q <= '0;
      env_q <= '0;
    end else begin
      va_q  <= va_d;
      vb_q  <= vb_d;
      mag_q <= mag_d;
      env_q <= env_d;
    end
  end

  assign valid_o = vb_q;
  assign env_o   = env_q;

endmodule

// File: rtl/compressor.sv
// Feed-forward compressor: envelope follower, adaptive Q1.15 gain and output
// scaling in a 3-stage pipeline. COMPRESSOR_GAIN_MON_EN adds the gain_o port.
module compressor
  import compressor_pkg::*;
#(
  parameter int unsigned THRESHOLD     = 8192,
  parameter int unsigned RATIO_SHIFT   = 2,
  parameter int unsigned ATTACK_SHIFT  = 3,
  parameter int unsigned RELEASE_SHIFT = 12,
  parameter int unsigned GAIN_STEP     = 16,
  parameter gain_t       GAIN_MIN      = 16'h0800
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              en_i,
  input  logic              valid_i,
  input  logic [DWIDTH-1:0] data_i,
  output logic              valid_o,
  output logic [DWIDTH-1:0] data_o
`ifdef COMPRESSOR_GAIN_MON_EN
  ,
  output logic [GAIN_W-1:0] gain_o
`endif
);

  localparam int unsigned PROD_W = DWIDTH + GAIN_W;
  localparam int unsigned PEST_W = MAG_W + GAIN_W;

  logic [DWIDTH-1:0] x_a_q, x_a_d;
  logic [DWIDTH-1:0] x_b_q, x_b_d;
  logic [DWIDTH-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  gain_t             gain_q, gain_d;

  logic              vb;
  logic [ENV_W-1:0]  env;

  logic [MAG_W-1:0]         env_int_c;
  logic [MAG_W-1:0]         tgt_c;
  logic [PEST_W-1:0]        p_full_c;
  logic [GAIN_W-1:0]        p_c;
  logic [GAIN_W:0]          gain_up_c;
  gain_t                    gain_next_c;
  logic signed [PROD_W-1:0] prod_c;

  envelope_follower #(
    .ATTACK_SHIFT  (ATTACK_SHIFT),
    .RELEASE_SHIFT (RELEASE_SHIFT)
  ) u_env (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .valid_i (valid_i),
    .data_i  (data_i),
    .valid_o (vb),
    .env_o   (env)
  );

  // Gain loop: compare the envelope as it would appear after gain with the target.
  always_comb begin
    env_int_c = MAG_W'(env >> ENV_FRAC);
    tgt_c     = env_int_c;
    if (env_int_c > MAG_W'(THRESHOLD)) begin
      tgt_c = MAG_W'(THRESHOLD) + ((env_int_c - MAG_W'(THRESHOLD)) >> RATIO_SHIFT);
    end
    p_full_c    = PEST_W'(env_int_c) * PEST_W'(gain_q);
    p_c         = GAIN_W'(p_full_c >> 15);
    gain_up_c   = {1'b0, gain_q} + (GAIN_W+1)'(GAIN_STEP);
    gain_next_c = gain_q;
    if (p_c > GAIN_W'(tgt_c)) begin
      if ({1'b0, gain_q} < (GAIN_W+1)'(GAIN_MIN) + (GAIN_W+1)'(GAIN_STEP)) begin
        gain_next_c = GAIN_MIN;
      end else begin
        gain_next_c = gain_q - GAIN_W'(GAIN_STEP);
      end
    end else if (p_c < GAIN_W'(tgt_c)) begin
      if (gain_up_c > {1'b0, GAIN_UNITY}) begin
        gain_next_c = GAIN_UNITY;
      end else begin
        gain_next_c = gain_up_c[GAIN_W-1:0];
      end
    end
  end

  // Signed sample times unsigned gain; the top slice is a floor shift by 15.
  always_comb begin
    prod_c = $signed({{GAIN_W{x_b_q[DWIDTH-1]}}, x_b_q}) *
             $signed({{DWIDTH{1'b0}}, gain_q});
  end

  // Stage C: output uses the pre-update gain, then the gain steps.
  always_comb begin
    x_a_d   = data_i;
    x_b_d   = x_a_q;
    valid_d = vb;
    data_d  = data_q;
    gain_d  = gain_q;
    if (vb) begin
      if (en_i) begin
        data_d = DWIDTH'(prod_c >>> 15);
        gain_d = gain_next_c;
      end else begin
        data_d = x_b_q;
        gain_d = GAIN_UNITY;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      x_a_q   <= '0;
      x_b_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      gain_q  <= GAIN_UNITY;
    end else begin
      x_a_q   <= x_a_d;
      x_b_q   <= x_b_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      gain_q  <= gain_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
`ifdef COMPRESSOR_GAIN_MON_EN
  assign gain_o  = gain_q;
`endif

endmodule

// File: tb/tb_compressor.sv
// Self-checking bench for compressor: table vectors, directed corner sequences
// and randomized traffic against an arithmetic reference model.
module tb_compressor;

  logic        clk_i;
  logic        rst_n_i;
  logic        en_i;
  logic        valid_i;
  logic [15:0] data_i;
  logic        valid_o;
  logic [15:0] data_o;
`ifdef COMPRESSOR_GAIN_MON_EN
  logic [15:0] gain_o;
`endif

  compressor dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .en_i    (en_i),
    .valid_i (valid_i),
    .data_i  (data_i),
    .valid_o (valid_o),
    .data_o  (data_o)
`ifdef COMPRESSOR_GAIN_MON_EN
    ,
    .gain_o  (gain_o)
`endif
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    int          due;
    logic [15:0] d;
  } exp_t;

  typedef struct {
    logic [15:0] x;
    logic [15:0] exp;
  } vec_t;

  exp_t   q[$];
  int     cyc;
  int     total;
  int     bad;
  longint env_m;
  longint gain_m;
  logic signed [15:0] last_data;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Output monitor: every cycle either the scheduled sample or nothing.
  always @(negedge clk_i) begin
    if (rst_n_i) begin
      while (q.size() > 0 && q[0].due < cyc) begin
        chk("missed_output", 64'(q[0].due), 64'(cyc));
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].due == cyc) begin
        chk("valid_o", 64'(valid_o), 64'd1);
        chk("data_o", 64'($signed(data_o)), 64'($signed(q[0].d)));
        last_data = $signed(data_o);
        void'(q.pop_front());
      end else begin
        chk("valid_o_idle", 64'(valid_o), 64'd0);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #2;
    end
  endtask

  task automatic model_reset();
    q.delete();
    env_m  = 0;
    gain_m = 32768;
  endtask

  // Reference model: one sample at a time, straight from the arithmetic rules.
  task automatic send(input logic [15:0] x, input logic use_tab, input logic [15:0] tab_exp);
    longint xs, mag, m, ei, p, tgt;
    logic [15:0] y;
    xs  = longint'($signed(x));
    mag = (xs < 0) ? (-xs - 1) : xs;
    m   = mag * 4096;
    if (m > env_m) env_m = env_m + ((m - env_m) >>> 3);
    else           env_m = env_m - ((env_m - m) >>> 12);
    ei = env_m / 4096;
    if (en_i) begin
      y   = 16'((xs * gain_m) >>> 15);
      p   = (ei * gain_m) >>> 15;
      tgt = (ei > 8192) ? 8192 + ((ei - 8192) >>> 2) : ei;
      if (p > tgt)      gain_m = (gain_m - 16 < 2048) ? 2048 : gain_m - 16;
      else if (p < tgt) gain_m = (gain_m + 16 > 32768) ? 32768 : gain_m + 16;
    end else begin
      y      = x;
      gain_m = 32768;
    end
    q.push_back('{due: cyc + 3, d: use_tab ? tab_exp : y});
    valid_i = 1'b1;
    data_i  = x;
    @(posedge clk_i);
    #2;
    valid_i = 1'b0;
  endtask

  task automatic s(input logic [15:0] x);
    send(x, 1'b0, 16'h0);
  endtask

  task automatic drain();
    for (int i = 0; i < 12 && q.size() > 0; i++) idle(1);
    idle(2);
    chk("drain_pending", 64'(q.size()), 64'd0);
`ifdef COMPRESSOR_GAIN_MON_EN
    chk("gain_o", 64'(gain_o), 64'(gain_m));
`endif
  endtask

  task automatic set_en(input logic en);
    drain();
    en_i = en;
  endtask

  task automatic near(input string name, input int target, input int tol);
    int diff;
    diff = int'(last_data) - target;
    if (diff < 0) diff = -diff;
    chk(name, 64'(int'(last_data)), (diff <= tol) ? 64'(int'(last_data)) : 64'(target));
  endtask

  vec_t tab[4];

  initial begin
    cyc       = 0;
    total     = 0;
    bad       = 0;
    last_data = '0;
    rst_n_i   = 1'b0;
    en_i      = 1'b0;
    valid_i   = 1'b0;
    data_i    = '0;
    model_reset();

    tab[0] = '{16'h1234, 16'h1234};
    tab[1] = '{16'hFFFF, 16'hFFFF};
    tab[2] = '{16'h0000, 16'h0000};
    tab[3] = '{16'h7FFF, 16'h7FFF};

    repeat (3) @(posedge clk_i);
    #2;
    chk("reset_data_o", 64'(data_o), 64'd0);
    chk("reset_valid_o", 64'(valid_o), 64'd0);
`ifdef COMPRESSOR_GAIN_MON_EN
    chk("reset_gain_o", 64'(gain_o), 64'h8000);
`endif
    rst_n_i = 1'b1;
    idle(2);

    // Bypass: single strobe, then back-to-back strobes.
    set_en(1'b0);
    send(tab[0].x, 1'b1, tab[0].exp);
    drain();
    for (int i = 1; i < 4; i++) send(tab[i].x, 1'b1, tab[i].exp);
    drain();

    // Mid-stream reset drops the pipeline and the current output immediately.
    set_en(1'b1);
    s(16'd20000);
    s(-16'sd5000);
    s(16'd7);
    s(16'd9);
    rst_n_i = 1'b0;
    #1;
    chk("midreset_data_o", 64'(data_o), 64'd0);
    chk("midreset_valid_o", 64'(valid_o), 64'd0);
`ifdef COMPRESSOR_GAIN_MON_EN
    chk("midreset_gain_o", 64'(gain_o), 64'h8000);
`endif
    model_reset();
    idle(2);
    rst_n_i = 1'b1;
    idle(2);

    // Below threshold: unity gain throughout.
    for (int i = 0; i < 2000; i++) s(16'd4000);
    drain();
    chk("below_thr_last", 64'(int'(last_data)), 64'd4000);

    // Positive and negative compression, then full-scale input.
    for (int i = 0; i < 3000; i++) s(16'd24000);
    drain();
    near("pos_comp_settle", 12144, 32);
    for (int i = 0; i < 1500; i++) s(-16'sd24000);
    drain();
    near("neg_comp_settle", -12144, 32);
    for (int i = 0; i < 1500; i++) s(16'h7FFF);
    s(16'h8000);
    drain();

    // Release: charge the envelope, then silence until gain returns to unity.
    for (int i = 0; i < 1500; i++) s(16'd24000);
    for (int i = 0; i < 7000; i++) s(16'd0);
    drain();
`ifdef COMPRESSOR_GAIN_MON_EN
    chk("release_gain_unity", 64'(gain_o), 64'h8000);
`endif
    s(16'd16000);
    drain();
    chk("release_unity_out", 64'(int'(last_data)), 64'd16000);

    // Randomized traffic with gaps; enable changes between bursts.
    for (int b = 0; b < 8; b++) begin
      set_en(1'($urandom_range(0, 1)));
      for (int i = 0; i < 60; i++) begin
        s(16'($urandom));
        idle(int'($urandom_range(0, 2)));
      end
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
